cga_palette: RTL and testbench

- Pipelined text-mode colorizer, successor to the fixed IRGB-to-RGB565 mapper.
- Takes an 8-bit CGA attribute (background nibble, foreground nibble), a pixel-on bit and a display-enable bit.
- Resolves a 4-bit colour index, handling attribute blink, then looks it up in a 16-entry palette of parametrised RGB width.
- Sits between the character generator and the LCD pins; its timing is aligned to the vga-timing block's data-enable and vsync.

---
 rtl/cga_palette.sv | 162 ++++++++++++++++
 tb/tb_cga_palette.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cga_palette.sv
// rtl/cga_palette.sv - pipelined CGA text-mode attribute colorizer with 16-entry palette
//
// Resolves a 4-bit colour index from an 8-bit CGA attribute and a glyph pixel
// bit (with optional attribute blink), then looks it up in a 16-entry palette.
// Two clock latency, one pixel per clock, no stall.
//
// Optional feature macro: CGA_PALETTE_WR_EN
//   defined   - palette is a resettable register array with a write port
//   undefined - palette is a constant ROM; wr_* inputs are ignored
//
// Ports:
//   clk_i       pixel clock
//   rstn_i      asynchronous active-low reset
//   color_i     attribute {bi,br,bg,bb,fi,fr,fg,fb}
//   on_i        glyph pixel on
//   de_i        display enable
//   vsync_i     vertical sync, active-high, synchronous to clk_i
//   blink_en_i  1 = attribute bit 7 is blink flag, 0 = background intensity
//   wr_en_i     palette write strobe
//   wr_addr_i   palette index to write
//   wr_data_i   {r,g,b} value to write
//   red_o       red channel
//   green_o     green channel
//   blue_o      blue channel
//   de_o        display enable aligned with colour outputs
module cga_palette #(
  parameter int RW           = 5,
  parameter int GW           = 6,
  parameter int BW           = 5,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [7:0]          color_i,
  input  logic                on_i,
  input  logic                de_i,
  input  logic                vsync_i,
  input  logic                blink_en_i,
  input  logic                wr_en_i,
  input  logic [3:0]          wr_addr_i,
  input  logic [RW+GW+BW-1:0] wr_data_i,
  output logic [RW-1:0]       red_o,
  output logic [GW-1:0]       green_o,
  output logic [BW-1:0]       blue_o,
  output logic                de_o
);

  localparam int PW = RW + GW + BW;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_FRAMES - 1);

  // Default entry k: each channel is its channel bit alternated with the
  // intensity bit, MSB first, truncated to the channel width.
  function automatic logic [PW-1:0] default_entry(input logic [3:0] k);
    logic [RW-1:0] r;
    logic [GW-1:0] g;
    logic [BW-1:0] b;
    for (int j = 0; j < RW; j++) r[RW-1-j] = (j % 2 == 0) ? k[2] : k[3];
    for (int j = 0; j < GW; j++) g[GW-1-j] = (j % 2 == 0) ? k[1] : k[3];
    for (int j = 0; j < BW; j++) b[BW-1-j] = (j % 2 == 0) ? k[0] : k[3];
    return {r, g, b};
  endfunction

  // Stage 1 registers
  logic [7:0]    color_q;
  logic          on_q;
  logic          de_q;
  logic          blink_en_q;

  // Blink state
  logic          vsync_q;
  logic [CW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic          vs_rise;

  logic [3:0]    bg_idx;
  logic [3:0]    idx;
  logic [PW-1:0] pal_rd;

  assign vs_rise = vsync_i & ~vsync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vsync_q       <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      vsync_q <= vsync_i;
      if (vs_rise) begin
        if (blink_cnt_q == CNT_MAX) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      color_q    <= '0;
      on_q       <= 1'b0;
      de_q       <= 1'b0;
      blink_en_q <= 1'b0;
    end else begin
      color_q    <= color_i;
      on_q       <= on_i;
      de_q       <= de_i;
      blink_en_q <= blink_en_i;
    end
  end

  // With blink enabled bit 7 is the blink flag, so the background loses its
  // intensity bit; a blinking foreground shows background during the off phase.
  always_comb begin
    bg_idx = blink_en_q ? {1'b0, color_q[6:4]} : color_q[7:4];
    idx    = bg_idx;
    if (on_q && !(blink_en_q && color_q[7] && !blink_phase_q))
      idx = color_q[3:0];
  end

`ifdef CGA_PALETTE_WR_EN
  logic [PW-1:0] pal_q [16];

  // Read is combinational from the current array, so a same-edge write is
  // not visible to the stage-2 read until the following cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < 16; k++) pal_q[k] <= default_entry(4'(k));
    end else if (wr_en_i) begin
      pal_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign pal_rd = pal_q[idx];
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
  assign pal_rd    = default_entry(idx);
`endif

  // Stage 2
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
      de_o    <= 1'b0;
    end else begin
      de_o <= de_q;
      if (de_q) begin
        {red_o, green_o, blue_o} <= pal_rd;
      end else begin
        red_o   <= '0;
        green_o <= '0;
        blue_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cga_palette.sv
// tb/tb_cga_palette.sv - self-checking scoreboard bench for cga_palette
module tb_cga_palette;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  color_i = '0;
  logic        on_i = 1'b0;
  logic        de_i = 1'b0;
  logic        vsync_i = 1'b0;
  logic        blink_en_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [3:0]  wr_addr_i = '0;
  logic [15:0] wr_data_i = '0;
  logic [4:0]  red_o;
  logic [5:0]  green_o;
  logic [4:0]  blue_o;
  logic        de_o;

  cga_palette dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .color_i    (color_i),
    .on_i       (on_i),
    .de_i       (de_i),
    .vsync_i    (vsync_i),
    .blink_en_i (blink_en_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .red_o      (red_o),
    .green_o    (green_o),
    .blue_o     (blue_o),
    .de_o       (de_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  logic [15:0] mpal [16];
  logic        m_phase;
  int          m_cnt;
  logic        m_vs_prev;
  logic        we_n = 1'b0;
  logic [3:0]  wa_n = '0;
  logic [15:0] wd_n = '0;

  // Repeating {c,i} pattern, take the top W bits.
  function automatic logic [15:0] model_default(input logic [3:0] k);
    logic [7:0] pr, pg, pb;
    pr = {4{k[2], k[3]}};
    pg = {4{k[1], k[3]}};
    pb = {4{k[0], k[3]}};
    return {pr[7:3], pg[7:2], pb[7:3]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mpal[k] = model_default(4'(k));
    m_phase   = 1'b1;
    m_cnt     = 0;
    m_vs_prev = 1'b0;
    sb.delete();
  endtask

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic on, input logic de,
                      input logic ben, input logic vs);
    logic [3:0]  bg, idx;
    logic [16:0] exp;
    @(negedge clk_i);
    if (sb.size() == 2) chk("pixel", {de_o, red_o, green_o, blue_o}, sb.pop_front());
    if (vs && !m_vs_prev) begin
      if (m_cnt == 15) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    m_vs_prev = vs;
`ifdef CGA_PALETTE_WR_EN
    if (we_n) mpal[wa_n] = wd_n;
`endif
    bg  = ben ? {1'b0, c[6:4]} : c[7:4];
    idx = (on && !(ben && c[7] && !m_phase)) ? c[3:0] : bg;
    exp = de ? {1'b1, mpal[idx]} : 17'h0;
    sb.push_back(exp);
    color_i    = c;
    on_i       = on;
    de_i       = de;
    blink_en_i = ben;
    vsync_i    = vs;
    wr_en_i    = we_n;
    wr_addr_i  = wa_n;
    wr_data_i  = wd_n;
    we_n       = 1'b0;
  endtask

  task automatic vsync_pulses(input int n, input logic [7:0] c);
    for (int p = 0; p < n; p++) begin
      step(c, 1'b1, 1'b1, 1'b1, 1'b1);
      step(c, 1'b1, 1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("reset_out", {de_o, red_o, green_o, blue_o}, 17'h0);
    end
    rstn_i = 1'b1;

    // Foreground E, then background 1
    repeat (3) step(8'h1E, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(8'h1E, 1'b0, 1'b1, 1'b0, 1'b0);
    // Intensity background, blink off
    repeat (2) step(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    // de toggling
    for (int i = 0; i < 8; i++) step(8'h7B, 1'b1, logic'(i % 2), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(8'($urandom_range(0, 255)), 1'($urandom), 1'b0, 1'b0, 1'b0);

    // Blink: visible, hidden after 16 edges, visible after 16 more
    repeat (3) step(8'h9C, 1'b1, 1'b1, 1'b1, 1'b0);
    vsync_pulses(16, 8'h9C);
    repeat (3) step(8'h9C, 1'b1, 1'b1, 1'b1, 1'b0);
    step(8'h9C, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h9C, 1'b0, 1'b1, 1'b0, 1'b0);
    vsync_pulses(16, 8'h9C);
    repeat (3) step(8'h9C, 1'b1, 1'b1, 1'b1, 1'b0);

    // Palette write to 6; the pixel before the write reads the old value
    step(8'h06, 1'b1, 1'b1, 1'b0, 1'b0);
    we_n = 1'b1; wa_n = 4'd6; wd_n = {5'h15, 6'h15, 5'h00};
    step(8'h06, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(8'h06, 1'b1, 1'b1, 1'b0, 1'b0);

    // Enter hidden blink phase, then reset mid-frame
    vsync_pulses(16, 8'h06);
    step(8'h9C, 1'b1, 1'b1, 1'b1, 1'b0);
    step(8'h9C, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    if (sb.size() == 2) chk("pixel", {de_o, red_o, green_o, blue_o}, sb.pop_front());
    rstn_i = 1'b0;
    #1;
    chk("async_reset", {de_o, red_o, green_o, blue_o}, 17'h0);
    model_reset();
    color_i = '0; on_i = 1'b0; de_i = 1'b0; blink_en_i = 1'b0; vsync_i = 1'b0; wr_en_i = 1'b0;
    @(negedge clk_i);
    chk("reset_hold", {de_o, red_o, green_o, blue_o}, 17'h0);
    rstn_i = 1'b1;

    // Defaults restored, blink phase visible
    repeat (3) step(8'h06, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(8'h9C, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
